// File: rtl/uart_pkg.sv
// Shared UART definitions: frame format, default baud divisor and receiver state encoding.
// Imported by both the receiver and the transmitter so the two ends stay consistent.
package uart_pkg;

  localparam int   CYCLES_PER_BIT = 217;
  localparam int   DATA_BITS      = 8;
  localparam logic START_LVL      = 1'b0;
  localparam logic STOP_LVL       = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } uart_state_e;

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// The flops reset to RESET_VAL, so an idle-high line does not show a false edge after reset.
module uart_bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle data-valid and frame-error strobes.
//   state        | meaning
//   ST_IDLE      | line idle, waiting for a falling edge (only once armed after reset)
//   ST_START     | timing to the middle of the start bit, rejects glitches
//   ST_DATA      | sampling 8 data bits LSB first, one per bit period
//   ST_STOP      | timing to the middle of the stop bit, then deliver or flag error
//   ST_WAIT_HIGH | bad stop bit seen, waiting for the line to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int c_CYCLES_PER_BIT = CYCLES_PER_BIT
) (
  input  logic       i_CLK,
  input  logic       i_RESET,
  input  logic       i_SERIAL_DATA,
  output logic [7:0] o_PARALLEL_DATA,
  output logic       o_RX_DV,
  output logic       o_RX_ACTIVE,
  output logic       o_FRAME_ERR
);

  localparam int HALF = (c_CYCLES_PER_BIT - 1) / 2;
  localparam int CW   = $clog2(c_CYCLES_PER_BIT);
  localparam int IW   = $clog2(DATA_BITS);

  // START is entered with the counter at 0, so HALF-1 lands on cycle T0+HALF.
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(c_CYCLES_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [7:0]           data_q, data_d;
  logic                 dv_q, dv_d;
  logic                 fe_q, fe_d;
  logic [1:0]           flush_q;
  logic                 armed_q;

  uart_bit_sync #(.RESET_VAL(STOP_LVL)) u_sync (
    .clk_i (i_CLK),
    .rst_i (i_RESET),
    .d_i   (i_SERIAL_DATA),
    .q_o   (rx_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (armed_q && rx_s == START_LVL) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = (rx_s == START_LVL) ? ST_DATA : ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == IDX_LAST) state_d = ST_STOP;
          else                   idx_d   = idx_q + IW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s == STOP_LVL) begin
            data_d  = shift_q;
            dv_d    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s == STOP_LVL) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // armed_q blocks a line that was already low across reset from looking like a start edge;
  // flush_q skips the synchronizer's reset value so only the real line can arm it.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= 8'h00;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
      flush_q <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
      flush_q <= {flush_q[0], 1'b1};
      if (flush_q[1] && rx_s == STOP_LVL) armed_q <= 1'b1;
    end
  end

  assign o_PARALLEL_DATA = data_q;
  assign o_RX_DV         = dv_q;
  assign o_FRAME_ERR     = fe_q;
  assign o_RX_ACTIVE     = (state_q != ST_IDLE);

endmodule
